logistic_keystream_gen: RTL and testbench

Parametrised logistic-map keystream generator, x(n+1) = mu*x(n)*(1-x(n)), in unsigned fixed point. One iteration per clock during a configurable burn-in phase. After burn-in it streams num_words state words over a valid/ready handshake, then pulses done. It adds configurable width, a streaming output, rounding mode and abort. It feeds downstream cipher/XOR stages in the encryption datapath.

---
 rtl/logistic_keystream_gen.sv | 124 ++++++++++++
 tb/tb_logistic_keystream_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/logistic_keystream_gen.sv
// Logistic-map keystream generator: x <= mu*x*(1-x) in unsigned fixed point,
// with a discarded burn-in phase followed by a valid/ready word stream.
`timescale 1ns/1ps
module logistic_keystream_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int MU_WIDTH   = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [MU_WIDTH-1:0]   mu,
  input  logic [CNT_WIDTH-1:0]  burn_in,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic                  round_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  // Handshake: a word transfers on a rising clk edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready is low,
  // out_data is held stable. abort overrides a coincident transfer.

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WARMUP = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam int W  = DATA_WIDTH;
  localparam int M  = MU_WIDTH;
  localparam int PW = M + 2*W + 1;
  localparam int F  = M - 2 + 2*W;

  logic [1:0]           state;
  logic [W-1:0]         x;
  logic [M-1:0]         mu_r;
  logic [CNT_WIDTH-1:0] burn_r;
  logic [CNT_WIDTH-1:0] nw_r;
  logic                 round_r;
  logic [CNT_WIDTH-1:0] cnt;

  logic [W:0]    om;
  logic [PW-1:0] prod;
  logic [PW-1:0] prod_r;
  logic [PW-1:0] shifted;
  logic [W-1:0]  fx;
  logic [W-1:0]  next_x;

  always_comb begin
    om      = {1'b1, {W{1'b0}}} - {1'b0, x};
    prod    = PW'(mu_r) * PW'(x) * PW'(om);
    prod_r  = prod + (round_r ? (PW'(1) << (F - W - 1)) : '0);
    shifted = prod_r >> (F - W);
    // Rounding can carry up to 1.0, which Q0.W cannot hold: saturate.
    if (|shifted[PW-1:W]) fx = '1;
    else                  fx = shifted[W-1:0];
    // Zero is a fixed point of the map; nudge off it by one LSB.
    next_x = (fx == '0) ? W'(1) : fx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      x       <= '0;
      mu_r    <= '0;
      burn_r  <= '0;
      nw_r    <= '0;
      round_r <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x       <= seed;
            mu_r    <= mu;
            round_r <= round_en;
            burn_r  <= burn_in;
            nw_r    <= num_words;
            cnt     <= '0;
            if (burn_in != '0)        state <= S_WARMUP;
            else if (num_words != '0) state <= S_STREAM;
            else                      state <= S_FINISH;
          end
        end
        S_WARMUP: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            x <= next_x;
            if (cnt == burn_r - 1'b1) begin
              cnt   <= '0;
              state <= (nw_r != '0) ? S_STREAM : S_FINISH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (out_ready) begin
            x   <= next_x;
            cnt <= cnt + 1'b1;
            if (cnt == nw_r - 1'b1) state <= S_FINISH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_data  = x;
  assign out_valid = (state == S_STREAM);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FINISH);
  assign dbg_state = state;

endmodule

// File: tb/tb_logistic_keystream_gen.sv
// Directed bench for logistic_keystream_gen using hand-computed Q0.16 values.
`timescale 1ns/1ps
module tb_logistic_keystream_gen;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, round_en, out_ready;
  logic [15:0] seed, mu, out_data;
  logic [7:0]  burn_in, num_words;
  logic        out_valid, busy, done;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logistic_keystream_gen #(.DATA_WIDTH(16), .MU_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .mu(mu), .burn_in(burn_in), .num_words(num_words), .round_en(round_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] s, input logic [15:0] m,
                           input logic [7:0] b, input logic [7:0] n,
                           input logic r);
    seed = s; mu = m; burn_in = b; num_words = n; round_en = r; start = 1'b1;
    tick();
    start = 1'b0;
    seed = 16'h1234; mu = 16'h0100; burn_in = 8'd7; num_words = 8'd9; round_en = ~r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; out_ready = 1'b1;
    seed = 16'hAAAA; mu = 16'hF000; burn_in = 0; num_words = 1; round_en = 0;
    tick(); tick();
    start = 1'b0;
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", out_data); end
    checks++; if ({out_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {out_valid, busy, done}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] exp_w [3];
    exp_w[0] = 16'h8000; exp_w[1] = 16'hF000; exp_w[2] = 16'h3840;
    out_ready = 1'b1;
    start_run(16'h8000, 16'hF000, 8'd0, 8'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin errors++; $display("FAIL basic_word%0d got v=%b %h exp v=1 %h", i, out_valid, out_data, exp_w[i]); end
      tick();
    end
    checks++; if ({done, busy, out_valid} !== 3'b110) begin errors++; $display("FAIL basic_done got %b exp 110", {done, busy, out_valid}); end
    tick();
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL basic_idle got %b exp 00", {done, busy}); end
  endtask

  task automatic test_burn_in();
    out_ready = 1'b1;
    start_run(16'h8000, 16'hF000, 8'd2, 8'd1, 1'b0);
    checks++; if ({busy, out_valid} !== 2'b10) begin errors++; $display("FAIL burn_c1 got %b exp 10", {busy, out_valid}); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL burn_c2 got %b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h3840) begin errors++; $display("FAIL burn_word got v=%b %h exp v=1 3840", out_valid, out_data); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL burn_done got %b exp 1", done); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    start_run(16'h8000, 16'hF000, 8'd0, 8'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h8000) begin errors++; $display("FAIL bp_hold%0d got v=%b %h exp v=1 8000", i, out_valid, out_data); end
      if (i == 1) begin seed = 16'h0F0F; start = 1'b1; end
      tick();
      start = 1'b0;
    end
    out_ready = 1'b1;
    checks++; if (out_data !== 16'h8000) begin errors++; $display("FAIL bp_word0 got %h exp 8000", out_data); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hF000) begin errors++; $display("FAIL bp_word1 got v=%b %h exp v=1 f000", out_valid, out_data); end
    tick();
    checks++; if ({done, out_valid} !== 2'b10) begin errors++; $display("FAIL bp_done got %b exp 10", {done, out_valid}); end
    tick();
  endtask

  task automatic test_escape();
    out_ready = 1'b1;
    start_run(16'h0000, 16'hF000, 8'd0, 8'd2, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0000) begin errors++; $display("FAIL esc_word0 got v=%b %h exp v=1 0000", out_valid, out_data); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0001) begin errors++; $display("FAIL esc_word1 got v=%b %h exp v=1 0001", out_valid, out_data); end
    tick(); tick();
  endtask

  task automatic test_zero_len();
    out_ready = 1'b1;
    start_run(16'h8000, 16'hF000, 8'd0, 8'd0, 1'b0);
    checks++; if ({done, busy, out_valid} !== 3'b110) begin errors++; $display("FAIL zero_finish got %b exp 110", {done, busy, out_valid}); end
    tick();
    checks++; if ({done, busy, out_valid} !== 3'b000) begin errors++; $display("FAIL zero_idle got %b exp 000", {done, busy, out_valid}); end
  endtask

  task automatic test_rounding(input logic r, input logic [15:0] exp_second);
    out_ready = 1'b1;
    start_run(16'h0001, 16'hFFFF, 8'd0, 8'd2, r);
    checks++; if (out_data !== 16'h0001) begin errors++; $display("FAIL round%0d_word0 got %h exp 0001", r, out_data); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== exp_second) begin errors++; $display("FAIL round%0d_word1 got v=%b %h exp v=1 %h", r, out_valid, out_data, exp_second); end
    tick(); tick();
  endtask

  task automatic test_abort();
    int saw_bad = 0;
    out_ready = 1'b1;
    start_run(16'h8000, 16'hF000, 8'd100, 8'd1, 1'b0);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({busy, done, out_valid} !== 3'b000) begin errors++; $display("FAIL abort_warm got %b exp 000", {busy, done, out_valid}); end
    for (int i = 0; i < 3; i++) begin
      if (done !== 1'b0 || out_valid !== 1'b0) saw_bad++;
      tick();
    end
    checks++; if (saw_bad !== 0) begin errors++; $display("FAIL abort_quiet got %0d exp 0", saw_bad); end
    // abort during a live handshake: the word is not consumed
    start_run(16'h8000, 16'hF000, 8'd0, 8'd3, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({busy, done, out_valid} !== 3'b000 || out_data !== 16'h8000) begin errors++; $display("FAIL abort_stream got %b %h exp 000 8000", {busy, done, out_valid}, out_data); end
    start_run(16'h8000, 16'hF000, 8'd0, 8'd1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h8000) begin errors++; $display("FAIL abort_rerun got v=%b %h exp v=1 8000", out_valid, out_data); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_rerun_done got %b exp 1", done); end
    tick();
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b1;
    start_run(16'h8000, 16'hF000, 8'd0, 8'd3, 1'b0);
    tick();
    checks++; if (out_data !== 16'hF000) begin errors++; $display("FAIL rst_pre got %h exp f000", out_data); end
    rst_n = 1'b0;
    tick();
    checks++; if ({out_data, out_valid, busy, done} !== 19'd0) begin errors++; $display("FAIL rst_mid got %h %b%b%b exp 0000 000", out_data, out_valid, busy, done); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_burn_in();
    test_backpressure();
    test_escape();
    test_zero_len();
    test_rounding(1'b0, 16'h0003);
    test_rounding(1'b1, 16'h0004);
    test_abort();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
